fau_seq: RTL

- Initiator/controller that drives the field arithmetic unit's data port.
- Accepts one micro-op per handshake from the ECC point-arithmetic engine: opcode, destination and two source indices into a local operand register file.
- Drives the FAU control and operand lines, times completion with latency counters, and writes the result back.
- Sits between the ECC top-level sequencer and the FAU instance.

---
 rtl/fau_seq_pkg.sv | 46 ++++
 rtl/fau_seq_regfile.sv | 51 +++++
 rtl/fau_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fau_seq_pkg.sv
// fau_seq_pkg: opcode and state encodings, default latencies and small
// helpers shared by the FAU micro-op sequencer and its register file.
package fau_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_MUL   = 2'b10,
      OP_ADDNR = 2'b11
   } fau_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_WB    = 2'b11
   } seq_state_e;

   localparam int FAU_REG_SIZE_DEF = 384;
   localparam int FAU_NUM_REGS_DEF = 8;
   localparam int FAU_ADD_LAT_DEF  = 2;
   localparam int FAU_MULT_LAT_DEF = 40;

   // Larger of two integers, used to size the latency counter.
   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   // FAU control lines per opcode, returned as {sub, red}.
   function automatic logic [1:0] op_ctrl(input fau_op_e op);
      logic [1:0] ctrl;
      case (op)
         OP_ADD:   ctrl = 2'b01;
         OP_SUB:   ctrl = 2'b11;
         OP_MUL:   ctrl = 2'b00;
         OP_ADDNR: ctrl = 2'b00;
         default:  ctrl = 2'b00;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/fau_seq_regfile.sv
// fau_seq_regfile: NUM_REGS x REG_SIZE operand store. One synchronous write
// port (the sequencer muxes write-back and host writes onto it), two
// combinational operand read ports and one combinational host read port.
module fau_seq_regfile
   import fau_seq_pkg::*;
#(
   parameter int REG_SIZE = FAU_REG_SIZE_DEF,
   parameter int NUM_REGS = FAU_NUM_REGS_DEF,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                we_i,
   input  logic [AW-1:0]       waddr_i,
   input  logic [REG_SIZE-1:0] wdata_i,
   input  logic [AW-1:0]       raddr_a_i,
   input  logic [AW-1:0]       raddr_b_i,
   input  logic [AW-1:0]       raddr_h_i,
   output logic [REG_SIZE-1:0] rdata_a_o,
   output logic [REG_SIZE-1:0] rdata_b_o,
   output logic [REG_SIZE-1:0] rdata_h_o
);

   logic [REG_SIZE-1:0] mem_q [NUM_REGS];
   logic [REG_SIZE-1:0] mem_d [NUM_REGS];

   // Next-state of every entry: replace the addressed one on a write.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         mem_d[i] = (we_i && (waddr_i == AW'(i))) ? wdata_i : mem_q[i];
      end
   end

   // Storage; reset clears the whole file.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign rdata_a_o = mem_q[raddr_a_i];
   assign rdata_b_o = mem_q[raddr_b_i];
   assign rdata_h_o = mem_q[raddr_h_i];

endmodule

// File: rtl/fau_seq.sv
// fau_seq: micro-op sequencer driving the field arithmetic unit. Accepts one
// op per handshake, presents operands/controls from ISSUE through WB, times
// completion with a latency counter and writes the result back.
// Optional build macro FAU_SEQ_OPMASK_EN: zero operand and control lines
// whenever no operation is in flight.
module fau_seq
   import fau_seq_pkg::*;
#(
   parameter int REG_SIZE     = FAU_REG_SIZE_DEF,
   parameter int NUM_REGS     = FAU_NUM_REGS_DEF,
   parameter int ADD_LATENCY  = FAU_ADD_LAT_DEF,
   parameter int MULT_LATENCY = FAU_MULT_LAT_DEF,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [AW-1:0]       cmd_dst_i,
   input  logic [AW-1:0]       cmd_srca_i,
   input  logic [AW-1:0]       cmd_srcb_i,
   output logic                done_o,
   output logic                busy_o,
   input  logic                host_we_i,
   input  logic [AW-1:0]       host_addr_i,
   input  logic [REG_SIZE-1:0] host_wdata_i,
   output logic [REG_SIZE-1:0] host_rdata_o,
   output logic                host_err_o,
   input  logic                err_clr_i,
   output logic                fau_sub_o,
   output logic                fau_red_o,
   output logic                fau_mult_start_o,
   output logic [REG_SIZE-1:0] fau_opa_o,
   output logic [REG_SIZE-1:0] fau_opb_o,
   input  logic [REG_SIZE-1:0] fau_add_res_i,
   input  logic [REG_SIZE-1:0] fau_mult_res_i
);

   localparam int CW = $clog2(max_int(ADD_LATENCY, MULT_LATENCY) + 1);

   seq_state_e          state_q, state_d;
   fau_op_e             op_q, op_d;
   logic [AW-1:0]       dst_q, dst_d;
   logic [REG_SIZE-1:0] opa_q, opa_d, opb_q, opb_d;
   logic                sub_q, sub_d, red_q, red_d;
   logic                mstart_q, mstart_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                host_ok_s;
   logic                wb_we_s;
   logic [REG_SIZE-1:0] wb_data_s;
   logic                rf_we_s;
   logic [AW-1:0]       rf_waddr_s;
   logic [REG_SIZE-1:0] rf_wdata_s;
   logic [REG_SIZE-1:0] rd_a_s, rd_b_s;
   logic [REG_SIZE-1:0] opa_fwd_s, opb_fwd_s;

   // Host writes only land while idle; busy writes are dropped.
   assign host_ok_s = host_we_i && !busy_q;

   // A host write in the accept cycle must be seen by the captured operands.
   assign opa_fwd_s = (host_ok_s && (host_addr_i == cmd_srca_i)) ? host_wdata_i : rd_a_s;
   assign opb_fwd_s = (host_ok_s && (host_addr_i == cmd_srcb_i)) ? host_wdata_i : rd_b_s;

   // Single write port: write-back wins (host is never accepted while busy).
   assign rf_we_s    = wb_we_s || host_ok_s;
   assign rf_waddr_s = wb_we_s ? dst_q : host_addr_i;
   assign rf_wdata_s = wb_we_s ? wb_data_s : host_wdata_i;

   fau_seq_regfile #(
      .REG_SIZE (REG_SIZE),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .clk       (clk),
      .reset_n   (reset_n),
      .we_i      (rf_we_s),
      .waddr_i   (rf_waddr_s),
      .wdata_i   (rf_wdata_s),
      .raddr_a_i (cmd_srca_i),
      .raddr_b_i (cmd_srcb_i),
      .raddr_h_i (host_addr_i),
      .rdata_a_o (rd_a_s),
      .rdata_b_o (rd_b_s),
      .rdata_h_o (host_rdata_o)
   );

   // Next-state, operand/control capture, latency counting and write-back.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_d     = dst_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      sub_d     = sub_q;
      red_d     = red_q;
      mstart_d  = 1'b0;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      wb_we_s   = 1'b0;
      wb_data_s = fau_add_res_i;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i && ready_q) begin
               op_d           = fau_op_e'(cmd_op_i);
               dst_d          = cmd_dst_i;
               opa_d          = opa_fwd_s;
               opb_d          = opb_fwd_s;
               {sub_d, red_d} = op_ctrl(fau_op_e'(cmd_op_i));
               mstart_d       = (fau_op_e'(cmd_op_i) == OP_MUL);
               state_d        = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
`ifdef FAU_SEQ_OPMASK_EN
               opa_d   = '0;
               opb_d   = '0;
               sub_d   = 1'b0;
               red_d   = 1'b0;
`endif
            end
         end
         ST_ISSUE: begin
            cnt_d   = (op_q == OP_MUL) ? CW'(MULT_LATENCY - 1) : CW'(ADD_LATENCY - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_WB;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_WB: begin
            wb_we_s   = 1'b1;
            wb_data_s = (op_q == OP_MUL) ? fau_mult_res_i : fau_add_res_i;
            state_d   = ST_IDLE;
`ifdef FAU_SEQ_OPMASK_EN
            opa_d     = '0;
            opb_d     = '0;
            sub_d     = 1'b0;
            red_d     = 1'b0;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state; sticky host error flag.
   always_comb begin
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
      err_d   = err_q;
      if (err_clr_i) begin
         err_d = 1'b0;
      end else if (host_we_i && busy_q) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ADD;
         dst_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         sub_q    <= 1'b0;
         red_q    <= 1'b0;
         mstart_q <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dst_q    <= dst_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sub_q    <= sub_d;
         red_q    <= red_d;
         mstart_q <= mstart_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign cmd_ready_o      = ready_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign host_err_o       = err_q;
   assign fau_sub_o        = sub_q;
   assign fau_red_o        = red_q;
   assign fau_mult_start_o = mstart_q;
   assign fau_opa_o        = opa_q;
   assign fau_opb_o        = opb_q;

endmodule
